serial_chunk_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder: adds a + b + cin CHUNK bits per clock,
//   LSB chunk first, through a CHUNK-bit full-adder chain and a carry flop.

---
 rtl/serial_chunk_adder.sv | 128 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle WIDTH-bit adder computing a + b + cin, CHUNK bits per clock.
//   The LSB chunk is added first. A carry flop links consecutive chunks.
//   Handshake: start is accepted while idle, busy covers the run, and done
//   pulses for one cycle when sum/cout/ovf are updated.

module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Reject parameter combinations that cannot be split into whole chunks.
    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] chunk_wide;
    logic [WIDTH-1:0] next_res;

    assign busy = (state == RUN);

    // CHUNK-bit ripple full-adder chain over the low bits of both operands.
    always_comb begin
        logic cy;
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        chunk_sum = '0;
        msb_cin   = carry;
        cy        = carry;
        for (int i = 0; i < CHUNK; i++) begin
            // Carry entering the top bit of the chunk; on the last step this is
            // the carry into the operand MSB, needed for signed overflow.
            if (i == CHUNK - 1) begin
                msb_cin = cy;
            end
            chunk_sum[i] = op_a[i] ^ op_b[i] ^ cy;
            cy           = (op_a[i] & op_b[i]) | (cy & (op_a[i] ^ op_b[i]));
        end
        chunk_cout = cy;
    end

    // Result register shifts right by CHUNK, new chunk enters from the top.
    always_comb begin
        chunk_wide                = '0;
        chunk_wide[CHUNK-1:0]     = chunk_sum;
        next_res = (res >> CHUNK) | (chunk_wide << (WIDTH - CHUNK));
    end

    // Control FSM, operand shift registers, carry flop and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    carry <= chunk_cout;
                    res   <= next_res;
                    if (cnt == LAST) begin
                        sum   <= next_res;
                        cout  <= chunk_cout;
                        ovf   <= msb_cin ^ chunk_cout;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder
//   Directed checks of serial_chunk_adder: an 8-bit/1-bit-chunk instance for
//   handshake, latency, overflow and reset behaviour, and a 4-bit/2-bit-chunk
//   instance swept over every operand/carry combination.

module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_chunk_adder #(.WIDTH(4), .CHUNK(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done on the 8-bit instance; cyc = edges since accept.
    task automatic wait_done8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done8 !== 1'b1 && cyc < 40);
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done4 !== 1'b1 && cyc < 20);
    endtask

    // One complete 8-bit addition, started from an idle cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input string tag);
        int cyc;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(cyc);
        chk({tag, "_lat"},  32'(cyc),   32'd8);
        chk({tag, "_sum"},  32'(sum8),  32'(es));
        chk({tag, "_cout"}, 32'(cout8), 32'(ec));
        chk({tag, "_ovf"},  32'(ovf8),  32'(eo));
        chk({tag, "_idle"}, 32'(busy8), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int cyc;
        int extra;
        int held_ok;
        int sa, sb, s, ref_sum, ref_cout, ref_ovf;

        // Reset state.
        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_ovf",  32'(ovf8),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrap from all-ones, signed overflow cases, carry-in.
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "a5_5a_c");

        // cin only, with start held high throughout busy: one done only.
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy", 32'(busy8), 32'd1);
        wait_done8(cyc);
        start8 = 1'b0;
        chk("hold_lat",  32'(cyc),   32'd8);
        chk("hold_sum",  32'(sum8),  32'h01);
        chk("hold_cout", 32'(cout8), 32'd0);
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done8 !== 1'b0 || busy8 !== 1'b0) extra++;
        end
        chk("hold_no_extra", 32'(extra), 32'd0);

        // Back-to-back: restart in the done cycle; old sum held until done.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(cyc);
        chk("b2b_first_sum", 32'(sum8), 32'h30);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b_busy", 32'(busy8), 32'd1);
        cyc = 0;
        held_ok = 1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (done8 !== 1'b1 && sum8 !== 8'h30) held_ok = 0;
        end while (done8 !== 1'b1 && cyc < 40);
        chk("b2b_lat",  32'(cyc),     32'd8);
        chk("b2b_sum",  32'(sum8),    32'h46);
        chk("b2b_held", 32'(held_ok), 32'd1);

        // Reset mid-operation: outputs clear at once, the op is dropped.
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy_pre", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy8), 32'd0);
        chk("mid_done", 32'(done8), 32'd0);
        chk("mid_sum",  32'(sum8),  32'd0);
        chk("mid_cout", 32'(cout8), 32'd0);
        chk("mid_ovf",  32'(ovf8),  32'd0);
        #2;
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8 !== 1'b0 || busy8 !== 1'b0) extra++;
        end
        chk("mid_no_done", 32'(extra), 32'd0);
        run8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "post_rst");

        // WIDTH=4, CHUNK=2: every a, b, cin; each start lands in the done cycle
        // of the previous op (after the first).
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    @(posedge clk);
                    #1;
                    start4 = 1'b0;
                    wait_done4(cyc);
                    ref_sum  = (ia + ib + ic) % 16;
                    ref_cout = (ia + ib + ic) / 16;
                    sa = (ia >= 8) ? ia - 16 : ia;
                    sb = (ib >= 8) ? ib - 16 : ib;
                    s  = sa + sb + ic;
                    ref_ovf = (s > 7 || s < -8) ? 1 : 0;
                    chk($sformatf("w4_a%0d_b%0d_c%0d", ia, ib, ic),
                        32'((cyc << 8) | (int'(cout4) << 5) | (int'(ovf4) << 4) | int'(sum4)),
                        32'((2 << 8) | (ref_cout << 5) | (ref_ovf << 4) | ref_sum));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
